mips_cpu_alu_ctrl: RTL and testbench

Multi-cycle decode/sequencing controller that drives the control side of `mips_cpu_alu`. It accepts one instruction word per handshake, decodes it into `alu_func`/`shift`/`mult_op`/`alu_write`, and samples the ALU `condition` back. From that it produces register-file write strobes and the branch decision. It sits between instruction fetch and the ALU/register file in the CPU datapath.

---
 rtl/mips_cpu_alu_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_mips_cpu_alu_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_alu_ctrl.sv
// Multi-cycle IDLE/DECODE/EXEC/WB sequencer that decodes MIPS words into mips_cpu_alu controls.
// Define MIPS_CPU_DIV_STALL_EN to hold DIV/DIVU in EXEC for DIV_CYCLES cycles.
module mips_cpu_alu_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  alu_func,
    output logic [4:0]  shift,
    output logic [2:0]  mult_op,
    output logic        alu_write,
    output logic        imm_sel,
    input  logic        condition,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic        branch_taken,
    output logic        illegal,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    if (DIV_CYCLES < 1 || DIV_CYCLES > 63) begin : g_div_cycles_range
        $error("DIV_CYCLES must be in the range 1-63");
    end

    state_t      state;
    logic [31:0] instr_q;

    logic [5:0] opcode;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
    logic       unused_rs;

    assign opcode    = instr_q[31:26];
    assign rt        = instr_q[20:16];
    assign rd        = instr_q[15:11];
    assign shamt     = instr_q[10:6];
    assign funct     = instr_q[5:0];
    assign unused_rs = ^instr_q[25:21];

    logic [4:0] dec_alu_func;
    logic [4:0] dec_shift;
    logic [2:0] dec_mult_op;
    logic       dec_imm_sel;
    logic       dec_writer;
    logic [4:0] dec_waddr;
    logic       dec_branch;
    logic       dec_taken_when;
    logic       dec_div;
    logic       dec_illegal;

    // Per-instruction facts needed at the EXEC->WB edge.
    logic wb_writer;
    logic wb_branch;
    logic wb_taken_when;
    logic wb_illegal;
    logic exec_last;

`ifdef MIPS_CPU_DIV_STALL_EN
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);
    logic [5:0] stall_cnt;
    assign exec_last = (stall_cnt == 6'd0);
`else
    assign exec_last = 1'b1;
`endif

    always_comb begin
        dec_alu_func   = 5'b00000;
        dec_shift      = shamt;
        dec_mult_op    = 3'b000;
        dec_imm_sel    = 1'b0;
        dec_writer     = 1'b0;
        dec_waddr      = 5'd0;
        dec_branch     = 1'b0;
        dec_taken_when = 1'b1;
        dec_div        = 1'b0;
        dec_illegal    = 1'b0;
        case (opcode)
            6'h00: begin
                dec_writer = 1'b1;
                dec_waddr  = rd;
                case (funct)
                    6'h21: dec_alu_func = 5'b00000;
                    6'h24: dec_alu_func = 5'b00001;
                    6'h25: dec_alu_func = 5'b00010;
                    6'h23: dec_alu_func = 5'b00011;
                    6'h2A: dec_alu_func = 5'b00100;
                    6'h2B: dec_alu_func = 5'b00101;
                    6'h26: dec_alu_func = 5'b01100;
                    6'h00: dec_alu_func = 5'b00110;
                    6'h04: dec_alu_func = 5'b00111;
                    6'h02: dec_alu_func = 5'b01000;
                    6'h06: dec_alu_func = 5'b01001;
                    6'h03: dec_alu_func = 5'b01010;
                    6'h07: dec_alu_func = 5'b01011;
                    6'h10: dec_mult_op  = 3'b111;
                    6'h12: dec_mult_op  = 3'b110;
                    6'h18: begin
                        dec_mult_op = 3'b001;
                        dec_writer  = 1'b0;
                    end
                    6'h19: begin
                        dec_mult_op = 3'b010;
                        dec_writer  = 1'b0;
                    end
                    6'h1A: begin
                        dec_mult_op = 3'b011;
                        dec_writer  = 1'b0;
                        dec_div     = 1'b1;
                    end
                    6'h1B: begin
                        dec_mult_op = 3'b100;
                        dec_writer  = 1'b0;
                        dec_div     = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h09: begin
                dec_alu_func = 5'b00000;
                dec_imm_sel  = 1'b1;
                dec_writer   = 1'b1;
                dec_waddr    = rt;
            end
            // BEQ's ALU compare reports inequality, so BEQ is taken on a low condition.
            6'h04: begin
                dec_alu_func   = 5'b10001;
                dec_branch     = 1'b1;
                dec_taken_when = 1'b0;
            end
            6'h05: begin
                dec_alu_func = 5'b10001;
                dec_branch   = 1'b1;
            end
            6'h06: begin
                dec_alu_func = 5'b01111;
                dec_branch   = 1'b1;
            end
            6'h07: begin
                dec_alu_func = 5'b01110;
                dec_branch   = 1'b1;
            end
            6'h01: begin
                case (rt)
                    5'd0: begin
                        dec_alu_func = 5'b10000;
                        dec_branch   = 1'b1;
                    end
                    5'd1: begin
                        dec_alu_func = 5'b01101;
                        dec_branch   = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_alu_func = 5'b00000;
            dec_shift    = 5'd0;
            dec_mult_op  = 3'b000;
            dec_imm_sel  = 1'b0;
            dec_writer   = 1'b0;
            dec_waddr    = 5'd0;
            dec_branch   = 1'b0;
            dec_div      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            instr_q       <= 32'd0;
            instr_ready   <= 1'b1;
            alu_func      <= 5'd0;
            shift         <= 5'd0;
            mult_op       <= 3'd0;
            alu_write     <= 1'b0;
            imm_sel       <= 1'b0;
            rf_we         <= 1'b0;
            rf_waddr      <= 5'd0;
            branch_taken  <= 1'b0;
            illegal       <= 1'b0;
            done          <= 1'b0;
            wb_writer     <= 1'b0;
            wb_branch     <= 1'b0;
            wb_taken_when <= 1'b0;
            wb_illegal    <= 1'b0;
`ifdef MIPS_CPU_DIV_STALL_EN
            stall_cnt     <= 6'd0;
`endif
        end else begin
            alu_write    <= 1'b0;
            rf_we        <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    alu_func      <= dec_alu_func;
                    shift         <= dec_shift;
                    mult_op       <= dec_mult_op;
                    imm_sel       <= dec_imm_sel;
                    rf_waddr      <= dec_writer ? dec_waddr : 5'd0;
                    alu_write     <= (dec_mult_op >= 3'd1) && (dec_mult_op <= 3'd4);
                    wb_writer     <= dec_writer;
                    wb_branch     <= dec_branch;
                    wb_taken_when <= dec_taken_when;
                    wb_illegal    <= dec_illegal;
`ifdef MIPS_CPU_DIV_STALL_EN
                    stall_cnt     <= dec_div ? DIV_LOAD : 6'd0;
`endif
                    state         <= EXEC;
                end
                EXEC: begin
                    if (exec_last) begin
                        rf_we        <= wb_writer;
                        branch_taken <= wb_branch && (condition == wb_taken_when);
                        illegal      <= wb_illegal;
                        done         <= 1'b1;
                        state        <= WB;
                    end
`ifdef MIPS_CPU_DIV_STALL_EN
                    else begin
                        stall_cnt <= stall_cnt - 6'd1;
                    end
`endif
                end
                WB: begin
                    alu_func    <= 5'd0;
                    shift       <= 5'd0;
                    mult_op     <= 3'd0;
                    imm_sel     <= 1'b0;
                    rf_waddr    <= 5'd0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_alu_ctrl.sv
// Self-checking bench for mips_cpu_alu_ctrl: directed cases plus randomized traffic against a
// transaction-level model (cycle offset from acceptance decides every expected output).
`timescale 1ns/1ps
module tb_mips_cpu_alu_ctrl;

    localparam int DIV_CYC = 4;
`ifdef MIPS_CPU_DIV_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  alu_func;
    logic [4:0]  shift;
    logic [2:0]  mult_op;
    logic        alu_write;
    logic        imm_sel;
    logic        condition;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        branch_taken;
    logic        illegal;
    logic        done;

    mips_cpu_alu_ctrl #(.DIV_CYCLES(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_func(alu_func), .shift(shift), .mult_op(mult_op),
        .alu_write(alu_write), .imm_sel(imm_sel), .condition(condition), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .branch_taken(branch_taken), .illegal(illegal), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    typedef struct packed {
        logic [4:0] alu_func;
        logic [4:0] shift;
        logic [2:0] mult_op;
        logic       imm_sel;
        logic       writer;
        logic [4:0] waddr;
        logic       branch;
        logic       taken_when;
        logic       illegal;
        logic       is_div;
    } dec_t;

    // R-type lookup: kind 0 illegal, 1 ALU writer, 2 HI/LO read (writer), 3 HI/LO write.
    int         r_kind [64];
    logic [4:0] r_alu  [64];
    logic [2:0] r_mult [64];

    task automatic setR(input int f, input int kind, input logic [4:0] a, input logic [2:0] m);
        r_kind[f] = kind;
        r_alu[f]  = a;
        r_mult[f] = m;
    endtask

    task automatic buildTables();
        for (int i = 0; i < 64; i++) setR(i, 0, 5'd0, 3'd0);
        setR('h21, 1, 5'b00000, 3'd0); setR('h24, 1, 5'b00001, 3'd0);
        setR('h25, 1, 5'b00010, 3'd0); setR('h23, 1, 5'b00011, 3'd0);
        setR('h2A, 1, 5'b00100, 3'd0); setR('h2B, 1, 5'b00101, 3'd0);
        setR('h26, 1, 5'b01100, 3'd0); setR('h00, 1, 5'b00110, 3'd0);
        setR('h04, 1, 5'b00111, 3'd0); setR('h02, 1, 5'b01000, 3'd0);
        setR('h06, 1, 5'b01001, 3'd0); setR('h03, 1, 5'b01010, 3'd0);
        setR('h07, 1, 5'b01011, 3'd0);
        setR('h10, 2, 5'b00000, 3'b111); setR('h12, 2, 5'b00000, 3'b110);
        setR('h18, 3, 5'b00000, 3'b001); setR('h19, 3, 5'b00000, 3'b010);
        setR('h1A, 3, 5'b00000, 3'b011); setR('h1B, 3, 5'b00000, 3'b100);
    endtask

    function automatic dec_t modelDecode(input logic [31:0] w);
        dec_t d;
        int   op;
        int   f;
        int   rt;
        d  = '0;
        op = int'(w[31:26]);
        f  = int'(w[5:0]);
        rt = int'(w[20:16]);
        if (op == 0) begin
            d.alu_func = r_alu[f];
            d.mult_op  = r_mult[f];
            d.writer   = (r_kind[f] == 1) || (r_kind[f] == 2);
            d.waddr    = d.writer ? w[15:11] : 5'd0;
            d.is_div   = (f == 'h1A) || (f == 'h1B);
            d.illegal  = (r_kind[f] == 0);
        end else if (op == 'h09) begin
            d.imm_sel = 1'b1;
            d.writer  = 1'b1;
            d.waddr   = w[20:16];
        end else if (op >= 4 && op <= 7) begin
            d.branch     = 1'b1;
            d.taken_when = (op != 4);
            d.alu_func   = (op <= 5) ? 5'b10001 : ((op == 6) ? 5'b01111 : 5'b01110);
        end else if (op == 1 && rt < 2) begin
            d.branch     = 1'b1;
            d.taken_when = 1'b1;
            d.alu_func   = (rt == 0) ? 5'b10000 : 5'b01101;
        end else begin
            d.illegal = 1'b1;
        end
        if (!d.illegal) d.shift = w[10:6];
        return d;
    endfunction

    // Transaction model: m_k is the cycle number counted from the accepting edge.
    logic m_busy = 1'b0;
    int   m_k    = 0;
    int   m_len  = 1;
    dec_t m_dec  = '0;
    logic m_cond = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_k == 1 + m_len) m_cond = condition;
            m_k++;
            if (m_k == 3 + m_len) m_busy = 1'b0;
        end else if (instr_valid) begin
            m_busy = 1'b1;
            m_k    = 1;
            m_dec  = modelDecode(instr);
            m_len  = (STALL && m_dec.is_div) ? DIV_CYC : 1;
        end
    end

    always @(posedge clk) begin
        logic in_exec;
        logic in_wb;
        #1;
        in_exec = m_busy && (m_k >= 2);
        in_wb   = m_busy && (m_k == 2 + m_len);
        checkOutput("model_instr_ready", instr_ready, !m_busy);
        checkOutput("model_alu_func", alu_func, in_exec ? m_dec.alu_func : 5'd0);
        checkOutput("model_shift", shift, in_exec ? m_dec.shift : 5'd0);
        checkOutput("model_mult_op", mult_op, in_exec ? m_dec.mult_op : 3'd0);
        checkOutput("model_imm_sel", imm_sel, in_exec && m_dec.imm_sel);
        checkOutput("model_rf_waddr", rf_waddr, (in_exec && m_dec.writer) ? m_dec.waddr : 5'd0);
        checkOutput("model_alu_write", alu_write,
                    m_busy && (m_k == 2) && (m_dec.mult_op >= 3'd1) && (m_dec.mult_op <= 3'd4));
        checkOutput("model_rf_we", rf_we, in_wb && m_dec.writer);
        checkOutput("model_branch_taken", branch_taken,
                    in_wb && m_dec.branch && (m_cond == m_dec.taken_when));
        checkOutput("model_illegal", illegal, in_wb && m_dec.illegal);
        checkOutput("model_done", done, in_wb);
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a word for one accepting edge; returns #1 into cycle 1 (DECODE).
    task automatic applyStimulus(input logic [31:0] word, input logic cond_val);
        @(negedge clk);
        instr       = word;
        instr_valid = 1'b1;
        condition   = cond_val;
        nextCycle();
        instr_valid = 1'b0;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        logic [5:0]  legal_f [19];
        logic [5:0]  ops [6];
        int          sel;
        legal_f = '{6'h21, 6'h24, 6'h25, 6'h23, 6'h2A, 6'h2B, 6'h26, 6'h00, 6'h04, 6'h02,
                    6'h06, 6'h03, 6'h07, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};
        ops = '{6'h09, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01};
        w   = $urandom();
        sel = $urandom_range(0, 9);
        if (sel >= 1 && sel <= 5) begin
            w[31:26] = 6'h00;
            if ($urandom_range(0, 7) != 0) w[5:0] = legal_f[$urandom_range(0, 18)];
        end else if (sel >= 6) begin
            w[31:26] = ops[$urandom_range(0, 5)];
            if (w[31:26] == 6'h01 && $urandom_range(0, 3) != 0) w[20:16] = 5'($urandom_range(0, 1));
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int got;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        condition   = 1'b0;
        buildTables();
        repeat (2) nextCycle();
        checkOutput("reset_instr_ready", instr_ready, 1);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_rf_we", rf_we, 0);
        checkOutput("reset_mult_op", mult_op, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] directed: ADDU r3,r1,r2");
        applyStimulus(32'h00221821, 1'b0);
        checkOutput("addu_c1_ready", instr_ready, 0);
        nextCycle();
        checkOutput("addu_c2_alu_func", alu_func, 5'b00000);
        checkOutput("addu_c2_rf_we", rf_we, 0);
        nextCycle();
        checkOutput("addu_c3_rf_we", rf_we, 1);
        checkOutput("addu_c3_rf_waddr", rf_waddr, 3);
        checkOutput("addu_c3_done", done, 1);
        nextCycle();
        checkOutput("addu_c4_ready", instr_ready, 1);

        $display("[TB] directed: SRA r4,r5,7");
        applyStimulus(32'h000521C3, 1'b0);
        nextCycle();
        checkOutput("sra_c2_alu_func", alu_func, 5'b01010);
        checkOutput("sra_c2_shift", shift, 7);
        nextCycle();
        checkOutput("sra_c3_rf_waddr", rf_waddr, 4);
        checkOutput("sra_c3_rf_we", rf_we, 1);
        nextCycle();

        $display("[TB] directed: BEQ both conditions");
        applyStimulus(32'h10220005, 1'b0);
        nextCycle();
        checkOutput("beq0_c2_alu_func", alu_func, 5'b10001);
        nextCycle();
        checkOutput("beq0_c3_taken", branch_taken, 1);
        checkOutput("beq0_c3_rf_we", rf_we, 0);
        nextCycle();
        applyStimulus(32'h10220005, 1'b1);
        repeat (2) nextCycle();
        checkOutput("beq1_c3_taken", branch_taken, 0);
        checkOutput("beq1_c3_rf_we", rf_we, 0);
        checkOutput("beq1_c3_done", done, 1);
        nextCycle();

        $display("[TB] directed: MULT then MFLO r8");
        applyStimulus(32'h00220018, 1'b0);
        nextCycle();
        checkOutput("mult_c2_alu_write", alu_write, 1);
        checkOutput("mult_c2_mult_op", mult_op, 3'b001);
        nextCycle();
        checkOutput("mult_c3_alu_write", alu_write, 0);
        checkOutput("mult_c3_rf_we", rf_we, 0);
        nextCycle();
        applyStimulus(32'h00004012, 1'b0);
        nextCycle();
        checkOutput("mflo_c2_mult_op", mult_op, 3'b110);
        checkOutput("mflo_c2_alu_write", alu_write, 0);
        nextCycle();
        checkOutput("mflo_c3_rf_we", rf_we, 1);
        checkOutput("mflo_c3_rf_waddr", rf_waddr, 8);
        nextCycle();

        $display("[TB] directed: DIV latency");
        applyStimulus(32'h0022001A, 1'b0);
        got = -1;
        for (int c = 2; c <= 20 && got < 0; c++) begin
            nextCycle();
            if (done === 1'b1) got = c;
        end
        checkOutput("div_done_cycle", got, STALL ? 2 + DIV_CYC : 3);
        nextCycle();
        checkOutput("div_ready_after", instr_ready, 1);

        $display("[TB] directed: illegal opcode then reset in DECODE");
        applyStimulus(32'hFC000000, 1'b0);
        repeat (2) nextCycle();
        checkOutput("ill_c3_illegal", illegal, 1);
        checkOutput("ill_c3_done", done, 1);
        checkOutput("ill_c3_rf_we", rf_we, 0);
        nextCycle();
        applyStimulus(32'h00221821, 1'b0);
        reset = 1'b1;
        nextCycle();
        checkOutput("rst_mid_ready", instr_ready, 1);
        checkOutput("rst_mid_alu_func", alu_func, 0);
        checkOutput("rst_mid_done", done, 0);
        reset = 1'b0;
        nextCycle();
        checkOutput("rst_after_rf_we", rf_we, 0);
        checkOutput("rst_after_done", done, 0);
        checkOutput("rst_after_ready", instr_ready, 1);

        $display("[TB] directed: reset and valid on the same edge");
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 32'h00221821;
        nextCycle();
        reset       = 1'b0;
        instr_valid = 1'b0;
        nextCycle();
        checkOutput("rst_valid_not_accepted", instr_ready, 1);

        $display("[TB] random traffic");
        repeat (3000) begin
            @(negedge clk);
            reset       = ($urandom_range(0, 63) == 0);
            instr_valid = ($urandom_range(0, 2) != 0);
            instr       = randInstr();
            condition   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        reset       = 1'b0;
        instr_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
